oscope_axil_regs: RTL and testbench

AXI4-Lite responder (slave) providing the oscilloscope IP's software-visible register file. It terminates the S00_AXI port driven by the PS/VIP master. It also exposes four read/write configuration words to the capture datapath, returns two live status words, and issues a one-cycle arm command pulse. It sits between the AXI interconnect and the oscope capture/trigger logic, in the `s00_axi_aclk` domain.

---
 rtl/oscope_pkg.sv | 20 ++
 rtl/oscope_axil_regs.sv | 109 ++++++++++
 tb/tb_oscope_axil_regs.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oscope_pkg.sv
// oscope_pkg: shared word map, AXI response codes and FSM state types for the oscope register file.
package oscope_pkg;
  localparam logic [2:0] WORD_CFG0 = 3'd0;
  localparam logic [2:0] WORD_CFG1 = 3'd1;
  localparam logic [2:0] WORD_CFG2 = 3'd2;
  localparam logic [2:0] WORD_CFG3 = 3'd3;
  localparam logic [2:0] WORD_STATUS = 3'd4;
  localparam logic [2:0] WORD_SAMPLE_CNT = 3'd5;
  localparam logic [2:0] WORD_ID = 3'd6;
  localparam logic [2:0] WORD_CMD = 3'd7;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h05C0_0100;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    for (int b = 0; b < 4; b++) apply_strb[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
  endfunction
endpackage

// File: rtl/oscope_axil_regs.sv
// oscope_axil_regs: AXI4-Lite register file for the oscope IP (CFG0-3, live status, ID, arm command).
// Define OSCOPE_AXIL_SLVERR_EN to answer writes to the read-only words with SLVERR instead of OKAY.
module oscope_axil_regs
  import oscope_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     cfg_o [0:3],
  input  logic [31:0]                     status_i,
  input  logic [31:0]                     sample_cnt_i,
  output logic                            arm_pulse_o
);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [2:0] aw_idx_q, w_idx, r_idx;
  logic [31:0] wdata_q, w_data, r_data;
  logic [3:0] wstrb_q, w_strb;
  logic [1:0] w_resp;
  logic aw_hs, w_hs, ar_hs, commit, unused;
  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign commit = (w_state != W_RESP) && (w_next == W_RESP);
  // A channel latched earlier takes priority over the live bus value.
  assign w_idx = (w_state == W_HAVE_AW) ? aw_idx_q : s00_axi_awaddr[4:2];
  assign w_data = (w_state == W_HAVE_W) ? wdata_q : s00_axi_wdata;
  assign w_strb = (w_state == W_HAVE_W) ? wstrb_q : s00_axi_wstrb;
`ifdef OSCOPE_AXIL_SLVERR_EN
  assign w_resp = (w_idx[2] && w_idx != WORD_CMD) ? RESP_SLVERR : RESP_OKAY;
`else
  assign w_resp = RESP_OKAY;
`endif
  assign r_idx = s00_axi_araddr[4:2];
  assign r_data = !r_idx[2] ? cfg_o[r_idx[1:0]] :
                  r_idx == WORD_STATUS ? status_i :
                  r_idx == WORD_SAMPLE_CNT ? sample_cnt_i :
                  r_idx == WORD_ID ? ID_VALUE : '0;
  assign s00_axi_rresp = RESP_OKAY;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:    w_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : W_IDLE;
      W_HAVE_AW: w_next = w_hs ? W_RESP : W_HAVE_AW;
      W_HAVE_W:  w_next = aw_hs ? W_RESP : W_HAVE_W;
      default:   w_next = s00_axi_bready ? W_IDLE : W_RESP;
    endcase
    r_next = (r_state == R_IDLE) ? (ar_hs ? R_RESP : R_IDLE) : (s00_axi_rready ? R_IDLE : R_RESP);
  end
  // Readies are gated by the reset input so they read low while reset is held.
  always_comb begin
    s00_axi_awready = s00_axi_aresetn && (w_state == W_IDLE || w_state == W_HAVE_W);
    s00_axi_wready = s00_axi_aresetn && (w_state == W_IDLE || w_state == W_HAVE_AW);
    s00_axi_bvalid = w_state == W_RESP;
    s00_axi_arready = s00_axi_aresetn && r_state == R_IDLE;
    s00_axi_rvalid = r_state == R_RESP;
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      aw_idx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      s00_axi_bresp <= RESP_OKAY;
      s00_axi_rdata <= '0;
      arm_pulse_o <= 1'b0;
      for (int i = 0; i < 4; i++) cfg_o[i] <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= s00_axi_awaddr[4:2];
      if (w_hs) begin
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      if (commit) s00_axi_bresp <= w_resp;
      if (commit && !w_idx[2]) cfg_o[w_idx[1:0]] <= apply_strb(cfg_o[w_idx[1:0]], w_data, w_strb);
      arm_pulse_o <= commit && w_idx == WORD_CMD && w_data[0] && w_strb[0];
      if (ar_hs) s00_axi_rdata <= r_data;
    end
endmodule

// File: tb/tb_oscope_axil_regs.sv
// tb_oscope_axil_regs: randomized self-checking bench for oscope_axil_regs against a word-level model.
module tb_oscope_axil_regs;
  localparam logic [31:0] ID_EXP = 32'h05C0_0100;
`ifdef OSCOPE_AXIL_SLVERR_EN
  localparam logic [1:0] RO_RESP = 2'b10;
`else
  localparam logic [1:0] RO_RESP = 2'b00;
`endif
  logic clk = 0, aresetn = 1;
  logic [4:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid, arm;
  logic [31:0] wdata = 0, rdata, status = 0, scnt = 0;
  logic [3:0] wstrb = 0;
  logic [1:0] bresp, rresp;
  logic [31:0] cfg_o [0:3];
  logic [31:0] mdl [0:3];
  int errors = 0, checks = 0;

  oscope_axil_regs dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .cfg_o(cfg_o), .status_i(status), .sample_cnt_i(scnt), .arm_pulse_o(arm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m = 0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] expect_read(input int idx);
    case (idx)
      0, 1, 2, 3: return mdl[idx];
      4: return status;
      5: return scnt;
      6: return ID_EXP;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] expect_bresp(input int idx);
    return (idx >= 4 && idx <= 6) ? RO_RESP : 2'b00;
  endfunction

  // Applies the model side of a write: only CFG words store data.
  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < 4) mdl[idx] = merge(mdl[idx], d, s);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output int pulses);
    bit aw_p = 1, w_p = 1;
    int n = 0;
    lat = -1; pulses = 0; resp = 2'bxx;
    @(negedge clk);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 0;
    while ((aw_p || w_p) && n < 20) begin
      if (awready && aw_p) aw_p = 0;
      if (wready && w_p) w_p = 0;
      @(negedge clk); n++;
      awvalid = aw_p; wvalid = w_p;
    end
    n = 0;
    while (!bvalid && n < 20) begin pulses += int'(arm); @(negedge clk); n++; end
    if (bvalid) begin
      lat = n + 1; resp = bresp; pulses += int'(arm);
      bready = 1; @(negedge clk); pulses += int'(arm); bready = 0;
    end
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int n = 0;
    lat = -1; d = 'x; resp = 2'bxx;
    @(negedge clk);
    araddr = a; arvalid = 1; rready = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 0;
    status = $urandom; scnt = $urandom;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (rvalid) begin
      lat = n + 1; d = rdata; resp = rresp;
      rready = 1; @(negedge clk); rready = 0;
    end
  endtask

  task automatic test_reset;
    #1 aresetn = 0;
    #2;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, arm} !== 6'b0) begin
      errors++; $display("FAIL reset_hold: got %b need 000000", {awready, wready, arready, bvalid, rvalid, arm});
    end
    repeat (2) @(negedge clk);
    aresetn = 1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100 || bresp !== 0 || rresp !== 0 || rdata !== 0) begin
      errors++; $display("FAIL reset_idle: rdy/valid=%b bresp=%0d rresp=%0d rdata=%h",
                         {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cfg_o[i] !== 0) begin errors++; $display("FAIL reset_cfg%0d: got %h need 0", i, cfg_o[i]); end
      mdl[i] = 0;
    end
  endtask

  task automatic test_seq_write_read;
    logic [1:0] r; logic [31:0] d; int lat, p;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4 * i), 32'(i + 1), 4'hF, r, lat, p);
      model_write(i, 32'(i + 1), 4'hF);
      checks++;
      if (r !== 2'b00 || lat !== 1) begin errors++; $display("FAIL seq_b%0d: resp=%0d lat=%0d need 0/1", i, r, lat); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i), d, r, lat);
      checks++;
      if (d !== mdl[i] || r !== 2'b00 || lat !== 1 || cfg_o[i] !== mdl[i]) begin
        errors++; $display("FAIL seq_r%0d: rdata=%h rresp=%0d lat=%0d cfg=%h need %h", i, d, r, lat, cfg_o[i], mdl[i]);
      end
    end
  endtask

  task automatic test_order;
    logic [31:0] v = $urandom, v2 = $urandom;
    logic [1:0] r; int lat, p;
    @(negedge clk);
    wdata = v; wstrb = 4'hF; wvalid = 1; bready = 1;
    @(negedge clk); wvalid = 0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (wready !== 0 || awready !== 1 || bvalid !== 0) begin
      errors++; $display("FAIL order_wait: wready=%b awready=%b bvalid=%b need 0/1/0", wready, awready, bvalid);
    end
    awaddr = 5'h08; awvalid = 1;
    @(negedge clk); awvalid = 0;
    model_write(2, v, 4'hF);
    checks++;
    if (bvalid !== 1 || cfg_o[2] !== mdl[2]) begin
      errors++; $display("FAIL order_commit: bvalid=%b cfg2=%h need 1/%h", bvalid, cfg_o[2], mdl[2]);
    end
    @(negedge clk); bready = 0;
    checks++;
    if (bvalid !== 0) begin errors++; $display("FAIL order_single_b: bvalid=%b need 0", bvalid); end
    axi_write(5'h0E, v2, 4'hF, r, lat, p);
    model_write(3, v2, 4'hF);
    checks++;
    if (lat !== 1 || r !== 2'b00 || cfg_o[3] !== mdl[3]) begin
      errors++; $display("FAIL order_same: lat=%0d resp=%0d cfg3=%h need 1/0/%h", lat, r, cfg_o[3], mdl[3]);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] r; logic [31:0] d; int lat, p;
    axi_write(5'h04, 32'h11111111, 4'hF, r, lat, p);
    axi_write(5'h04, 32'hAABBCCDD, 4'b0101, r, lat, p);
    model_write(1, 32'h11111111, 4'hF);
    model_write(1, 32'hAABBCCDD, 4'b0101);
    axi_read(5'h04, d, r, lat);
    checks++;
    if (d !== 32'h11BB11DD || cfg_o[1] !== 32'h11BB11DD) begin
      errors++; $display("FAIL strobe: rdata=%h cfg1=%h need 11bb11dd", d, cfg_o[1]);
    end
  endtask

  task automatic test_cmd;
    logic [1:0] r; logic [31:0] d; int lat, p;
    axi_write(5'h1C, 32'h1, 4'hF, r, lat, p);
    checks++;
    if (p !== 1 || r !== 2'b00 || lat !== 1) begin
      errors++; $display("FAIL cmd_pulse: pulses=%0d resp=%0d lat=%0d need 1/0/1", p, r, lat);
    end
    axi_write(5'h1C, 32'h1, 4'b1110, r, lat, p);
    checks++;
    if (p !== 0) begin errors++; $display("FAIL cmd_nostrb: pulses=%0d need 0", p); end
    axi_write(5'h1C, 32'hFFFF_FFFE, 4'hF, r, lat, p);
    checks++;
    if (p !== 0) begin errors++; $display("FAIL cmd_bit0: pulses=%0d need 0", p); end
    axi_read(5'h1C, d, r, lat);
    checks++;
    if (d !== 0 || r !== 2'b00) begin errors++; $display("FAIL cmd_read: rdata=%h rresp=%0d need 0/0", d, r); end
  endtask

  task automatic test_ro_write;
    logic [1:0] r; logic [31:0] d, st; int lat, p;
    for (int idx = 4; idx <= 6; idx++) begin
      axi_write(5'(4 * idx), 32'h5, 4'hF, r, lat, p);
      checks++;
      if (r !== expect_bresp(idx) || p !== 0) begin
        errors++; $display("FAIL ro_bresp%0d: resp=%0d pulses=%0d need %0d/0", idx, r, p, expect_bresp(idx));
      end
    end
    st = status;
    axi_read(5'h10, d, r, lat);
    checks++;
    if (d !== st) begin errors++; $display("FAIL ro_status: rdata=%h need %h", d, st); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cfg_o[i] !== mdl[i]) begin errors++; $display("FAIL ro_cfg%0d: got %h need %h", i, cfg_o[i], mdl[i]); end
    end
  endtask

  task automatic test_read_backpressure;
    int n = 0;
    @(negedge clk);
    araddr = 5'h18; arvalid = 1; rready = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk); arvalid = 0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rvalid !== 1 || rdata !== ID_EXP || arready !== 0) begin
        errors++; $display("FAIL bp_cycle%0d: rvalid=%b rdata=%h arready=%b need 1/%h/0", c, rvalid, rdata, arready, ID_EXP);
      end
      status = $urandom;
      @(negedge clk);
    end
    rready = 1; @(negedge clk); rready = 0;
    checks++;
    if (rvalid !== 0 || arready !== 1) begin errors++; $display("FAIL bp_release: rvalid=%b arready=%b need 0/1", rvalid, arready); end
  endtask

  task automatic test_random;
    logic [1:0] r; logic [31:0] d, v, exp_d; logic [3:0] s; int lat, p, idx;
    for (int k = 0; k < 40; k++) begin
      idx = $urandom_range(0, 7);
      status = $urandom; scnt = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; s = 4'($urandom);
        axi_write(5'(4 * idx + $urandom_range(0, 3)), v, s, r, lat, p);
        model_write(idx, v, s);
        checks++;
        if (r !== expect_bresp(idx) || lat !== 1 || p !== int'(idx == 7 && v[0] && s[0])) begin
          errors++; $display("FAIL rnd_w%0d idx%0d: resp=%0d lat=%0d pulses=%0d", k, idx, r, lat, p);
        end
      end else begin
        exp_d = expect_read(idx);
        axi_read(5'(4 * idx + $urandom_range(0, 3)), d, r, lat);
        checks++;
        if (d !== exp_d || r !== 2'b00 || lat !== 1) begin
          errors++; $display("FAIL rnd_r%0d idx%0d: rdata=%h rresp=%0d lat=%0d need %h", k, idx, d, r, lat, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [1:0] r; logic [31:0] d, v = $urandom; int lat, p;
    @(negedge clk);
    awaddr = 5'h00; wdata = $urandom; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk); awvalid = 0; wvalid = 0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1) begin errors++; $display("FAIL mid_pending: bvalid=%b need 1", bvalid); end
    #2 aresetn = 0;
    #1;
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    checks++;
    if (bvalid !== 0 || cfg_o[0] !== 0 || cfg_o[1] !== 0 || cfg_o[2] !== 0 || cfg_o[3] !== 0 || awready !== 0) begin
      errors++; $display("FAIL mid_reset: bvalid=%b cfg0=%h cfg1=%h awready=%b", bvalid, cfg_o[0], cfg_o[1], awready);
    end
    @(negedge clk); aresetn = 1;
    @(negedge clk);
    axi_write(5'h0C, v, 4'hF, r, lat, p);
    model_write(3, v, 4'hF);
    axi_read(5'h0C, d, r, lat);
    checks++;
    if (d !== mdl[3] || lat !== 1) begin errors++; $display("FAIL mid_after: rdata=%h lat=%0d need %h/1", d, lat, mdl[3]); end
  endtask

  initial begin
    test_reset;
    test_seq_write_read;
    test_order;
    test_strobe;
    test_cmd;
    test_ro_write;
    test_read_backpressure;
    test_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
